// File: rtl/morse_freq_select.sv
// Frequency-select puzzle: an LFSR picks a target word, buttons steer freq_idx, tx checks it.
// Define MORSE_SEL_DEBOUNCE_EN to add a stable-count debounce filter on each button.
module morse_freq_select #(
    parameter int unsigned NUM_WORDS       = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_tx,
    output logic [15:0] data,
    output logic        set,
    output logic [3:0]  freq_idx,
    output logic        strike,
    output logic        solved,
    output logic [9:0]  debug_leds
);

    localparam logic [3:0] MAX_IDX = 4'(NUM_WORDS - 1);
    localparam logic [4:0] NW5     = 5'(NUM_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, CHECK, SOLVED} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic        lfsr_fb_c;
    logic [3:0]  pick_c;
    logic [3:0]  word, word_nxt, freq_nxt;
    logic [1:0]  strike_cnt, cnt_nxt;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_fb_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign pick_c    = ({1'b0, lfsr[3:0]} < NW5) ? lfsr[3:0] : 4'({1'b0, lfsr[3:0]} - NW5);

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr_fb_c};
    end

    // Button conditioning: {tx, right, left}
    logic [2:0] btn_raw, sync1, sync2, filt, prev, ev_c;
    logic [1:0] vld;
    logic       fvld, pvld;

    assign btn_raw = {btn_tx, btn_right, btn_left};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            vld   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
        end
    end

`ifdef MORSE_SEL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] db_cnt [3];

    // First valid sample seeds the filter so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            fvld <= 1'b0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else if (!fvld) begin
            if (vld[1]) begin
                filt <= sync2;
                fvld <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        filt[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync2;
    assign fvld = vld[1];
`endif

    // Rising-edge detect; the first valid filtered sample only primes prev
    assign ev_c = filt & ~prev & {3{pvld}};

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            pvld <= 1'b0;
        end else begin
            prev <= filt;
            pvld <= fvld;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        freq_nxt  = freq_idx;
        cnt_nxt   = strike_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    word_nxt  = pick_c;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = ARMED;
            ARMED: begin
                if (ev_c[2]) begin
                    state_nxt = CHECK;
                end else if (ev_c[0] && !ev_c[1]) begin
                    if (freq_idx != 4'd0) freq_nxt = freq_idx - 4'd1;
                end else if (ev_c[1] && !ev_c[0]) begin
                    if (freq_idx != MAX_IDX) freq_nxt = freq_idx + 4'd1;
                end
            end
            CHECK: begin
                if (freq_idx == word) begin
                    state_nxt = SOLVED;
                end else begin
                    if (strike_cnt != 2'd3) cnt_nxt = strike_cnt + 2'd1;
                    state_nxt = ARMED;
                end
            end
            SOLVED:  state_nxt = SOLVED;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode, so they track the state exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            data       <= '0;
            freq_idx   <= '0;
            strike_cnt <= '0;
            set        <= 1'b0;
            strike     <= 1'b0;
            solved     <= 1'b0;
        end else begin
            state      <= state_nxt;
            word       <= word_nxt;
            freq_idx   <= freq_nxt;
            strike_cnt <= cnt_nxt;
            set        <= (state_nxt == LOAD);
            strike     <= (state_nxt == CHECK) && (freq_nxt != word_nxt);
            solved     <= (state_nxt == SOLVED);
            if (state_nxt == LOAD) data <= {12'd0, word_nxt};
        end
    end

    assign debug_leds = {strike_cnt, word, freq_idx};

endmodule

// File: tb/tb_morse_freq_select.sv
// Randomized scoreboard bench for morse_freq_select against a press-level reference model.
module tb_morse_freq_select;

    localparam int unsigned NW  = 16;
    localparam int unsigned DEB = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef MORSE_SEL_DEBOUNCE_EN
    localparam int unsigned HOLD = DEB + 4;
`else
    localparam int unsigned HOLD = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, bl = 1'b0, br = 1'b0, bt = 1'b0;
    logic [15:0] data;
    logic        set, strike, solved;
    logic [3:0]  freq_idx;
    logic [9:0]  debug_leds;

    always #5 clk = ~clk;

    morse_freq_select #(.NUM_WORDS(NW), .LFSR_SEED(SEED), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_left(bl), .btn_right(br), .btn_tx(bt),
        .data(data), .set(set), .freq_idx(freq_idx), .strike(strike),
        .solved(solved), .debug_leds(debug_leds)
    );

    int checks = 0;
    int errors = 0;

    // kind: 0 = set pulse, 1 = strike pulse, 2 = solved rise
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
        logic [3:0]  freq;
        logic [1:0]  cnt;
    } exp_t;
    exp_t q[$];

    int         m_state;  // 0 idle, 1 armed, 2 solved
    logic [3:0] m_word, m_freq;
    logic [1:0] m_cnt;
    int         cyc;

    // Cycles since reset; the LFSR value equals SEED stepped this many times
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [3:0] pick(input int n);
        logic [15:0] l = SEED;
        for (int i = 0; i < n; i++) l = step(l);
        if (int'(l[3:0]) < int'(NW)) return l[3:0];
        return 4'(int'(l[3:0]) - int'(NW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits an event
    bit   set_pend = 0, str_pend = 0, prev_solved = 0;
    exp_t e_cur, e_str;
    int   obs;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (set_pend) begin
                chk("set_width", set, 0);
                set_pend = 0;
            end
            if (str_pend) begin
                chk("strike_width", strike, 0);
                chk("strike_cnt", debug_leds[9:8], e_str.cnt);
                str_pend = 0;
            end
            if (set || strike || (solved && !prev_solved)) begin
                obs = set ? 0 : (strike ? 1 : 2);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event kind=%0d expected=none t=%0t", obs, $time);
                end else begin
                    e_cur = q.pop_front();
                    chk("event_kind", obs, e_cur.kind);
                    chk("event_data", data, e_cur.data);
                    if (obs == 0) begin
                        chk("word_leds", debug_leds[7:4], e_cur.data[3:0]);
                        set_pend = 1;
                    end else begin
                        chk("event_freq", freq_idx, e_cur.freq);
                        if (obs == 1) begin
                            e_str    = e_cur;
                            str_pend = 1;
                        end
                    end
                end
            end
            prev_solved = solved;
        end
    end

    task automatic push(input logic [1:0] kind);
        q.push_back({kind, {12'd0, m_word}, m_freq, m_cnt});
    endtask

    task automatic do_reset(input bit hold_right);
        reset = 1; start = 0; bl = 0; br = hold_right; bt = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_set", set, 0);
        chk("rst_strike", strike, 0);
        chk("rst_solved", solved, 0);
        chk("rst_data", data, 0);
        chk("rst_leds", debug_leds, 0);
        chk("rst_queue", q.size(), 0);
        reset   = 0;
        m_state = 0; m_word = 0; m_freq = 0; m_cnt = 0;
    endtask

    task automatic do_start();
        start = 1;
        if (m_state == 0) begin
            m_word  = pick(cyc);
            push(2'd0);
            m_state = 1;
        end
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
    endtask

    // Apply one model press; events only matter while armed
    task automatic model_press(input bit l, input bit r, input bit t);
        if (m_state != 1) return;
        if (t) begin
            if (m_freq == m_word) begin
                push(2'd2);
                m_state = 2;
            end else begin
                if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
                push(2'd1);
            end
        end else if (l && !r) begin
            if (m_freq != 0) m_freq = m_freq - 4'd1;
        end else if (r && !l) begin
            if (m_freq != 4'(NW - 1)) m_freq = m_freq + 4'd1;
        end
    endtask

    task automatic press(input bit l, input bit r, input bit t);
        model_press(l, r, t);
        bl = l; br = r; bt = t;
        repeat (HOLD) @(negedge clk);
        bl = 0; br = 0; bt = 0;
        repeat (HOLD + 3) @(negedge clk);
        chk("freq_idx", freq_idx, m_freq);
    endtask

    int rnd;
    initial begin : stim
        m_state = 0; m_word = 0; m_freq = 0; m_cnt = 0;
        @(negedge clk);

        // Immediate start after reset picks word from the seed; right then tx solves
        do_reset(0);
        do_start();
        chk("first_word", data, 16'h0001);
        press(0, 1, 0);
        press(0, 0, 1);
        press(0, 1, 0);
        press(0, 0, 1);
        do_start();
        chk("solved_hold", solved, 1);
        chk("solved_freq", freq_idx, 4'd1);

        // Left saturates at 0; four wrong answers saturate the strike count
        do_reset(0);
        do_start();
        press(1, 0, 0);
        repeat (4) press(0, 0, 1);
        chk("strike_sat", debug_leds[9:8], 2'd3);
        press(1, 1, 0);
        press(1, 0, 1);

        // Reset during the LOAD cycle
        do_reset(0);
        start   = 1;
        m_word  = pick(cyc);
        push(2'd0);
        @(negedge clk);
        start = 0;
        chk("set_in_load", set, 1);
        do_reset(0);
        do_start();
        chk("reseed_word", data, 16'h0001);

        // Bouncing right button followed by a steady hold
        for (int i = 0; i < 20; i++) begin
            br = ((i >> 1) & 1) == 0;
            @(negedge clk);
        end
`ifdef MORSE_SEL_DEBOUNCE_EN
        model_press(0, 1, 0);
`else
        repeat (6) model_press(0, 1, 0);
`endif
        br = 1;
        repeat (HOLD + 5) @(negedge clk);
        br = 0;
        repeat (HOLD + 3) @(negedge clk);
        chk("bounce_freq", freq_idx, m_freq);
        press(0, 0, 1);

        // Button held through reset is not a press
        do_reset(1);
        do_start();
        repeat (6) @(negedge clk);
        br = 0;
        repeat (HOLD + 3) @(negedge clk);
        chk("held_rst_freq", freq_idx, 4'd0);
        press(0, 0, 1);

        // Randomized play
        do_reset(0);
        for (int n = 0; n < 90; n++) begin
            rnd = int'($urandom_range(0, 99));
            if (rnd < 4) begin
                do_reset(0);
            end else if (rnd < 14 || (m_state == 0 && rnd < 60)) begin
                do_start();
            end else if (rnd < 40) begin
                press(1, 0, 0);
            end else if (rnd < 75) begin
                press(0, 1, 0);
            end else if (rnd < 82) begin
                press(1, 1, 0);
            end else if (rnd < 95) begin
                press(0, 0, 1);
            end else begin
                press(0, 1, 1);
            end
            if (m_state == 2) chk("solved_level", solved, 1);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
